// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array and its sequencer.
//   seq_state_t : sequencer FSM states
//   DefaultSize : default array dimension (rows = columns)
//   DataW/MacW  : operand and accumulator widths used by the PE grid
package systolic_pkg;

    localparam int unsigned DefaultSize = 32;
    localparam int unsigned DataW       = 8;
    // Room for SIZE * 2^16 full-scale products without overflow.
    localparam int unsigned MacW        = 2 * DataW + 16 + $clog2(DefaultSize);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StFlush,
        StDrain,
        StDone
    } seq_state_t;

endpackage

// File: rtl/skew_window_gen.sv
// Per-lane read window and operand gate delay line for the skewed systolic feed.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_en          feed phase active (lane reads only allowed while set)
//   i_t           feed cycle count t
//   i_k           reduction depth K
//   o_lane_rd     lane i valid when i <= t <= i+K-1
//   o_lane_gate   o_lane_rd delayed RD_LAT cycles, cleared by rst
module skew_window_gen
    import systolic_pkg::*;
#(
    parameter int unsigned SIZE   = DefaultSize,
    parameter int unsigned K_W    = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic [K_W:0]    i_t,
    input  logic [K_W-1:0]  i_k,
    output logic [SIZE-1:0] o_lane_rd,
    output logic [SIZE-1:0] o_lane_gate
);

    // One spare bit so i+K never wraps.
    localparam int unsigned CmpW  = K_W + 2;
    localparam int unsigned PipeW = SIZE * RD_LAT;

    logic [CmpW-1:0]  w_t;
    logic [CmpW-1:0]  w_k;
    logic [PipeW-1:0] r_pipe;

    assign w_t = CmpW'(i_t);
    assign w_k = CmpW'(i_k);

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
        logic [CmpW-1:0] w_i;
        assign w_i = CmpW'(gi);
        // t <= i+K-1 written as t < i+K so K==0 never underflows
        assign o_lane_rd[gi] = i_en && (w_t >= w_i) && (w_t < w_i + w_k);
    end

    if (RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk) begin
            if (rst) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= o_lane_rd;
            end
        end
    end else begin : g_latn
        always_ff @(posedge clk) begin
            if (rst) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= {r_pipe[PipeW-SIZE-1:0], o_lane_rd};
            end
        end
    end

    assign o_lane_gate = r_pipe[PipeW-1 -: SIZE];

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a SIZE x SIZE output-stationary systolic MAC array. One start runs one
// C = A*B tile: clear accumulators, skewed operand feed, wavefront flush, row drain.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_start, i_k_len  launch a tile (IDLE only), reduction depth K captured on start
//   o_busy, o_done    not-IDLE flag, one-cycle completion pulse
//   o_pe_clear        PE accumulator clear
//   o_rd_en           operand-buffer read strobe
//   o_feed_idx        feed cycle t; lane i reads k = t-i
//   o_lane_rd         per-lane read valid
//   o_lane_gate       per-lane operand gate (lane_rd delayed RD_LAT)
//   o_drain_row, o_res_valid, i_res_ready, o_res_last   result drain handshake
//   o_perf_cycles     cycles of the last tile, CLEAR..DONE inclusive
//                     (present only when SYSTOLIC_SEQ_PERF_EN is defined)
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned SIZE   = DefaultSize,
    parameter int unsigned ADDR_W = $clog2(SIZE),
    parameter int unsigned K_W    = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [K_W-1:0]    i_k_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pe_clear,
    output logic              o_rd_en,
    output logic [K_W:0]      o_feed_idx,
    output logic [SIZE-1:0]   o_lane_rd,
    output logic [SIZE-1:0]   o_lane_gate,
    output logic [ADDR_W-1:0] o_drain_row,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic              o_res_last
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]       o_perf_cycles
`endif
);

    localparam logic [K_W:0]      FlushLast = (K_W + 1)'(SIZE + RD_LAT - 1);
    localparam logic [ADDR_W-1:0] LastRow   = ADDR_W'(SIZE - 1);

    seq_state_t        r_state, w_state_next;
    logic [K_W-1:0]    r_k, w_k_next;
    logic [K_W:0]      r_cnt, w_cnt_next;
    logic [ADDR_W-1:0] r_row, w_row_next;
    logic [K_W:0]      w_feed_last;
    logic              w_in_feed;
    logic              w_in_drain;

    // Last feed t is K+SIZE-2; FEED is only entered with K >= 1.
    assign w_feed_last = {1'b0, r_k} + (K_W + 1)'(SIZE - 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_k     <= '0;
            r_cnt   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
            r_cnt   <= w_cnt_next;
            r_row   <= w_row_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_cnt_next   = r_cnt;
        w_row_next   = r_row;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_k_next     = i_k_len;
                    w_cnt_next   = '0;
                    w_state_next = StClear;
                end
            end
            StClear: begin
                w_cnt_next   = '0;
                w_row_next   = '0;
                // K == 0: nothing to multiply, rows drain as cleared zeros
                w_state_next = (r_k == '0) ? StDrain : StFeed;
            end
            StFeed: begin
                if (r_cnt == w_feed_last) begin
                    w_cnt_next   = '0;
                    w_state_next = StFlush;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StFlush: begin
                if (r_cnt == FlushLast) begin
                    w_cnt_next   = '0;
                    w_state_next = StDrain;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StDrain: begin
                if (i_res_ready) begin
                    if (r_row == LastRow) begin
                        w_state_next = StDone;
                    end else begin
                        w_row_next = r_row + 1'b1;
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign w_in_feed   = (r_state == StFeed);
    assign w_in_drain  = (r_state == StDrain);

    assign o_busy      = (r_state != StIdle);
    assign o_done      = (r_state == StDone);
    assign o_pe_clear  = (r_state == StClear);
    assign o_rd_en     = w_in_feed;
    assign o_feed_idx  = w_in_feed ? r_cnt : '0;
    assign o_drain_row = w_in_drain ? r_row : '0;
    assign o_res_valid = w_in_drain;
    assign o_res_last  = w_in_drain && (r_row == LastRow);

    skew_window_gen #(
        .SIZE   (SIZE),
        .K_W    (K_W),
        .RD_LAT (RD_LAT)
    ) u_skew (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_in_feed),
        .i_t         (r_cnt),
        .i_k         (r_k),
        .o_lane_rd   (o_lane_rd),
        .o_lane_gate (o_lane_gate)
    );

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] r_run_cnt;
    logic [31:0] r_perf;

    // r_run_cnt holds the cycles spent before the current one, so DONE adds itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cnt <= '0;
            r_perf    <= '0;
        end else begin
            if (r_state == StIdle) begin
                r_run_cnt <= '0;
            end else if (r_run_cnt != '1) begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end
            if (r_state == StDone) begin
                r_perf <= (r_run_cnt == '1) ? r_run_cnt : r_run_cnt + 1'b1;
            end
        end
    end

    assign o_perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl at SIZE=4, RD_LAT=1, with a behavioural 4x4 PE grid and
// operand RAMs driven by the sequencer's strobes.
module tb_systolic_seq_ctrl;
    import systolic_pkg::*;

    localparam int unsigned SIZE   = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned K_W    = 16;
    localparam int unsigned RD_LAT = 1;
    localparam int          MAXK   = 8;
    localparam int unsigned PW     = 4 + (K_W + 1) + 2 * SIZE + ADDR_W + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [K_W-1:0]    k_len = '0;
    logic              res_ready = 1'b0;
    logic              busy, done, pe_clear, rd_en, res_valid, res_last;
    logic [K_W:0]      feed_idx;
    logic [SIZE-1:0]   lane_rd, lane_gate;
    logic [ADDR_W-1:0] drain_row;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    always #5 clk = ~clk;

    systolic_seq_ctrl #(
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W),
        .K_W    (K_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_k_len     (k_len),
        .o_busy      (busy),
        .o_done      (done),
        .o_pe_clear  (pe_clear),
        .o_rd_en     (rd_en),
        .o_feed_idx  (feed_idx),
        .o_lane_rd   (lane_rd),
        .o_lane_gate (lane_gate),
        .o_drain_row (drain_row),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_last  (res_last)
`ifdef SYSTOLIC_SEQ_PERF_EN
        ,
        .o_perf_cycles (perf_cycles)
`endif
    );

    int checks = 0;
    int failures = 0;

    int mat_a [SIZE][MAXK];
    int mat_b [MAXK][SIZE];

    // Operand RAMs (1-cycle read) and PE grid: A flows right, B flows down.
    int a_q [SIZE];
    int b_q [SIZE];
    int a_p [SIZE][SIZE];
    int b_p [SIZE][SIZE];
    int acc [SIZE][SIZE];

    always @(posedge clk) begin
        int idx, ai, bi;
        for (int i = 0; i < SIZE; i++) begin
            idx = int'(feed_idx) - i;
            if (rd_en && lane_rd[i] && idx >= 0 && idx < MAXK) begin
                a_q[i] <= mat_a[i][idx];
                b_q[i] <= mat_b[idx][i];
            end else begin
                a_q[i] <= 0;
                b_q[i] <= 0;
            end
        end
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                ai = (c == 0) ? (lane_gate[r] ? a_q[r] : 0) : a_p[r][c-1];
                bi = (r == 0) ? (lane_gate[c] ? b_q[c] : 0) : b_p[r-1][c];
                if (rst || pe_clear) begin
                    a_p[r][c] <= 0;
                    b_p[r][c] <= 0;
                    acc[r][c] <= 0;
                end else begin
                    a_p[r][c] <= ai;
                    b_p[r][c] <= bi;
                    acc[r][c] <= acc[r][c] + ai * bi;
                end
            end
        end
    end

    function automatic logic [PW-1:0] pack_out(
        input logic b, input logic d, input logic pc, input logic re,
        input logic [K_W:0] fi, input logic [SIZE-1:0] lr, input logic [SIZE-1:0] lg,
        input logic [ADDR_W-1:0] dr, input logic rv, input logic rl);
        return {b, d, pc, re, fi, lr, lg, dr, rv, rl};
    endfunction

    function automatic logic [PW-1:0] dut_out();
        return pack_out(busy, done, pe_clear, rd_en, feed_idx, lane_rd, lane_gate,
                        drain_row, res_valid, res_last);
    endfunction

    function automatic logic [SIZE-1:0] window(input int t, input int k);
        logic [SIZE-1:0] w;
        for (int i = 0; i < SIZE; i++) w[i] = (t >= i) && (t <= i + k - 1);
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_mats(input int mode, input int k);
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < MAXK; j++) begin
                mat_a[i][j] = 0;
                mat_b[j][i] = 0;
                if (j < k) begin
                    case (mode)
                        0: begin mat_a[i][j] = (i == j); mat_b[j][i] = (i == j); end
                        1: begin mat_a[i][j] = 1; mat_b[j][i] = 1; end
                        default: begin
                            mat_a[i][j] = $urandom_range(0, 15);
                            mat_b[j][i] = $urandom_range(0, 15);
                        end
                    endcase
                end
            end
        end
    endtask

    logic [SIZE-1:0] rd_hist [$];
    logic [SIZE-1:0] gate_hist [$];

    // Runs one tile; the model derives every cycle's outputs from K, the cycle index and
    // the number of accepted beats. stall: 0 always ready, 1 pattern 1,0,0, 2 random.
    task automatic run_tile(input int k, input int stall, input bit hold, output int busy_cyc);
        int n = 0, beats = 0, dc = 0, feed_len, flush_len;
        int exp_c [SIZE][SIZE];
        logic [SIZE-1:0] prev_rd = '0;
        logic [SIZE-1:0] e_rd;
        logic e_clr, e_rden, e_val, e_last, e_done, rdy, finished;
        logic [K_W:0] e_t;
        logic [ADDR_W-1:0] e_row;
        logic [63:0] act_row, exp_row;

        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                exp_c[r][c] = 0;
                for (int j = 0; j < k; j++) exp_c[r][c] += mat_a[r][j] * mat_b[j][c];
            end
        feed_len  = (k > 0) ? k + SIZE - 1 : 0;
        flush_len = (k > 0) ? SIZE + RD_LAT : 0;
        rd_hist.delete();
        gate_hist.delete();
        busy_cyc = 0;
        finished = 1'b0;

        @(negedge clk);
        start = 1'b1;
        k_len = K_W'(k);
        @(negedge clk);
        if (!hold) start = 1'b0;

        for (int guard = 0; guard < 400 && !finished; guard++) begin
            e_clr = 0; e_rden = 0; e_val = 0; e_last = 0; e_done = 0;
            e_t = '0; e_row = '0; e_rd = '0;
            if (n == 0) e_clr = 1;
            else if (n - 1 < feed_len) begin
                e_rden = 1;
                e_t = (K_W + 1)'(n - 1);
                e_rd = window(n - 1, k);
            end else if (n - 1 - feed_len < flush_len) begin
                // flush: only busy and the gate tail
            end else if (beats < SIZE) begin
                e_val = 1;
                e_row = ADDR_W'(beats);
                e_last = (beats == SIZE - 1);
            end else e_done = 1;

            rd_hist.push_back(lane_rd);
            gate_hist.push_back(lane_gate);
            busy_cyc += int'(busy);
            check($sformatf("outputs k=%0d n=%0d", k, n), 64'(dut_out()),
                  64'(pack_out(1'b1, e_done, e_clr, e_rden, e_t, e_rd, prev_rd, e_row,
                               e_val, e_last)));
            prev_rd = e_rd;

            if (e_done) begin
                finished = 1'b1;
            end else begin
                case (stall)
                    0: rdy = 1'b1;
                    1: rdy = (dc % 3 == 0);
                    default: rdy = ($urandom_range(0, 99) >= 30);
                endcase
                res_ready = rdy;
                if (e_val) begin
                    dc++;
                    if (rdy) begin
                        for (int c = 0; c < SIZE; c++) begin
                            act_row[c*16 +: 16] = 16'(acc[beats][c]);
                            exp_row[c*16 +: 16] = 16'(exp_c[beats][c]);
                        end
                        check($sformatf("row_data k=%0d row=%0d", k, beats), act_row, exp_row);
                        beats++;
                    end
                end
                n++;
                @(negedge clk);
            end
        end
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL tile_timeout k=%0d: got no done expected done", k);
        end

        res_ready = 1'b0;
        @(negedge clk);
        if (hold) start = 1'b0;
        check($sformatf("idle_after_done k=%0d", k), 64'(dut_out()), 64'd0);
`ifdef SYSTOLIC_SEQ_PERF_EN
        check($sformatf("perf_cycles k=%0d", k), 64'(perf_cycles), 64'(busy_cyc));
`endif
        if (hold) begin
            @(negedge clk);
            check("start_in_done_ignored", 64'(busy), 64'd0);
        end
    endtask

    typedef struct {
        int k;
        int mode;
        int stall;
        bit hold;
        int exp_cycles;
    } vec_t;

    initial begin
        vec_t vecs [6];
        logic [SIZE-1:0] k2_pat [5];
        int bc, kr;
        bit seen;

        vecs[0] = '{k: 3, mode: 0, stall: 0, hold: 1'b0, exp_cycles: 17};
        vecs[1] = '{k: 2, mode: 2, stall: 0, hold: 1'b0, exp_cycles: 16};
        vecs[2] = '{k: 0, mode: 2, stall: 0, hold: 1'b0, exp_cycles: 6};
        vecs[3] = '{k: 4, mode: 0, stall: 1, hold: 1'b0, exp_cycles: 24};
        vecs[4] = '{k: 7, mode: 2, stall: 0, hold: 1'b0, exp_cycles: 21};
        vecs[5] = '{k: 3, mode: 1, stall: 0, hold: 1'b1, exp_cycles: 17};
        k2_pat = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000};

        set_mats(1, 0);
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(dut_out()), 64'd0);
`ifdef SYSTOLIC_SEQ_PERF_EN
        check("reset_perf", 64'(perf_cycles), 64'd0);
`endif
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            set_mats(vecs[v].mode, vecs[v].k);
            run_tile(vecs[v].k, vecs[v].stall, vecs[v].hold, bc);
            check($sformatf("busy_cycles vec=%0d", v), 64'(bc), 64'(vecs[v].exp_cycles));
            if (vecs[v].k == 2) begin
                for (int t = 0; t < 5; t++) begin
                    check($sformatf("k2_lane_rd t=%0d", t), 64'(rd_hist[t + 1]), 64'(k2_pat[t]));
                    check($sformatf("k2_lane_gate t=%0d", t), 64'(gate_hist[t + 2]),
                          64'(k2_pat[t]));
                end
            end
        end

        // Reset in the middle of FEED, then a fresh tile must be unaffected.
        set_mats(1, 3);
        @(negedge clk);
        start = 1'b1;
        k_len = K_W'(3);
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int g = 0; g < 20 && !seen; g++) begin
            @(negedge clk);
            if (rd_en && feed_idx == 2) seen = 1'b1;
        end
        check("reached_feed_t2", 64'(seen), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_feed", 64'(dut_out()), 64'd0);
        rst = 1'b0;
        set_mats(1, 1);
        run_tile(1, 0, 1'b0, bc);
        check("busy_cycles after rst", 64'(bc), 64'd15);

        // Randomized tiles with random backpressure.
        for (int r = 0; r < 8; r++) begin
            kr = $urandom_range(0, MAXK - 1);
            set_mats(2, kr);
            run_tile(kr, 2, 1'b0, bc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
